// File: rtl/bf_run_ctrl.sv
// rtl/bf_run_ctrl.sv - program load / run / halt sequencer for the bf core
//
// Ports:
//   clk, resetq           clock, asynchronous active-low reset
//   load_valid/ready/data/last   program byte stream into code memory
//   start, abort          run request (level) and return-to-idle
//   code_we/waddr/wdata   code-memory write port
//   core_resetq           registered active-low reset to the core, high only in RUN
//   core_pc               core's next pc, compared against the program length
//   cycles, status        run-cycle count and result (0 none, 1 ok, 2 timeout, 3 overflow)
//   done, busy            one-cycle pulse on entering HALT; high in LOAD or RUN
`ifndef CADDR_WIDTH
`define CADDR_WIDTH 10
`endif

module bf_run_ctrl #(
  parameter int          CADDR_WIDTH = `CADDR_WIDTH,
  parameter int          CYC_W       = 24,
  parameter int unsigned MAX_CYCLES  = (32'd1 << CYC_W) - 32'd1
) (
  input  logic                   clk,
  input  logic                   resetq,
  input  logic                   load_valid,
  input  logic [7:0]             load_data,
  input  logic                   load_last,
  output logic                   load_ready,
  input  logic                   start,
  input  logic                   abort,
  output logic                   code_we,
  output logic [CADDR_WIDTH-1:0] code_waddr,
  output logic [7:0]             code_wdata,
  output logic                   core_resetq,
  input  logic [CADDR_WIDTH-1:0] core_pc,
  output logic [CYC_W-1:0]       cycles,
  output logic [1:0]             status,
  output logic                   done,
  output logic                   busy
);

  localparam int PW = CADDR_WIDTH + 1;
  localparam logic [CYC_W-1:0] TIMEOUT_AT = CYC_W'(MAX_CYCLES - 32'd1);

  localparam logic [1:0] ST_NONE     = 2'd0;
  localparam logic [1:0] ST_OK       = 2'd1;
  localparam logic [1:0] ST_TIMEOUT  = 2'd2;
  localparam logic [1:0] ST_OVERFLOW = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_READY = 3'd2,
    S_RUN   = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t                 state, state_n;
  logic [CADDR_WIDTH-1:0] wptr, wptr_n;
  logic [PW-1:0]          prog_len, prog_len_n;
  logic [CYC_W-1:0]       cycles_n;
  logic [1:0]             status_n;
  logic                   accept, do_load, go_run;

  assign load_ready = (state == S_IDLE) || (state == S_LOAD) || (state == S_HALT);
  assign busy       = (state == S_LOAD) || (state == S_RUN);
  assign accept     = load_valid && load_ready;
  assign code_wdata = load_data;
  // A load starting from HALT begins a fresh program at address 0.
  assign code_waddr = (state == S_HALT) ? '0 : wptr;

  always_comb begin
    state_n    = state;
    wptr_n     = wptr;
    prog_len_n = prog_len;
    cycles_n   = cycles;
    status_n   = status;
    code_we    = 1'b0;
    do_load    = 1'b0;
    go_run     = 1'b0;

    case (state)
      S_IDLE, S_LOAD: do_load = accept;
      S_READY:        go_run  = start;
      S_RUN: begin
        cycles_n = cycles + CYC_W'(1);
        // Normal end is checked first so it wins over a coincident timeout.
        if ({1'b0, core_pc} == prog_len) begin
          state_n  = S_HALT;
          status_n = ST_OK;
        end else if (cycles == TIMEOUT_AT) begin
          state_n  = S_HALT;
          status_n = ST_TIMEOUT;
        end
      end
      S_HALT: begin
        go_run  = start;
        do_load = accept && !start;
      end
      default: state_n = S_IDLE;
    endcase

    if (go_run) begin
      state_n  = S_RUN;
      cycles_n = '0;
      status_n = ST_NONE;
    end

    if (do_load) begin
      code_we = 1'b1;
      wptr_n  = code_waddr + CADDR_WIDTH'(1);
      if (load_last) begin
        prog_len_n = {1'b0, code_waddr} + PW'(1);
        state_n    = S_READY;
      end else if (&code_waddr) begin
        state_n  = S_HALT;
        status_n = ST_OVERFLOW;
      end else begin
        state_n = S_LOAD;
      end
    end

    // Abort overrides everything: no write, no counter/status update, and the
    // write pointer is rewound so the next load starts at address 0.
    if (abort) begin
      state_n    = S_IDLE;
      wptr_n     = '0;
      prog_len_n = prog_len;
      cycles_n   = cycles;
      status_n   = status;
      code_we    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state       <= S_IDLE;
      wptr        <= '0;
      prog_len    <= '0;
      cycles      <= '0;
      status      <= ST_NONE;
      done        <= 1'b0;
      core_resetq <= 1'b0;
    end else begin
      state       <= state_n;
      wptr        <= wptr_n;
      prog_len    <= prog_len_n;
      cycles      <= cycles_n;
      status      <= status_n;
      done        <= (state_n == S_HALT) && (state != S_HALT);
      core_resetq <= (state_n == S_RUN);
    end
  end

endmodule

// File: tb/tb_bf_run_ctrl.sv
// tb/tb_bf_run_ctrl.sv - directed self-checking bench for bf_run_ctrl
module tb_bf_run_ctrl;

  logic       clk = 1'b0;
  logic       resetq;
  logic       load_valid, load_last, load_ready;
  logic [7:0] load_data;
  logic       start, abort;
  logic       code_we;
  logic [1:0] code_waddr;
  logic [7:0] code_wdata;
  logic       core_resetq;
  logic [1:0] core_pc;
  logic [7:0] cycles;
  logic [1:0] status;
  logic       done, busy;

  int passed = 0;
  int total  = 0;

  // Core stand-in: pc held at 0 in reset, counts up while running;
  // core_pc is its next pc. 'stuck' pins it to 0 to force a timeout.
  logic       stuck = 1'b0;
  logic [1:0] pc;
  always_ff @(posedge clk) begin
    if (!core_resetq) pc <= 2'd0;
    else              pc <= pc + 2'd1;
  end
  assign core_pc = (core_resetq && !stuck) ? pc + 2'd1 : 2'd0;

  always #5 clk = ~clk;

  bf_run_ctrl #(.CADDR_WIDTH(2), .CYC_W(8), .MAX_CYCLES(8)) dut (
    .clk(clk), .resetq(resetq),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .start(start), .abort(abort),
    .code_we(code_we), .code_waddr(code_waddr), .code_wdata(code_wdata),
    .core_resetq(core_resetq), .core_pc(core_pc),
    .cycles(cycles), .status(status), .done(done), .busy(busy)
  );

  task automatic test_reset();
    resetq = 1'b0; load_valid = 1'b0; load_data = 8'h00; load_last = 1'b0;
    start = 1'b0; abort = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (load_ready !== 1'b1) $display("FAIL reset_load_ready: got %b want 1", load_ready); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if (core_resetq !== 1'b0) $display("FAIL reset_core_resetq: got %b want 0", core_resetq); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
    total++; if (cycles !== 8'd0) $display("FAIL reset_cycles: got %0d want 0", cycles); else passed++;
    total++; if (status !== 2'd0) $display("FAIL reset_status: got %0d want 0", status); else passed++;
    total++; if (code_we !== 1'b0) $display("FAIL reset_code_we: got %b want 0", code_we); else passed++;
    resetq = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load();
    logic [7:0] d [3] = '{8'h01, 8'h22, 8'h83};
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1; load_data = d[i]; load_last = (i == 2);
      #1;
      total++; if (code_we !== 1'b1) $display("FAIL load_we[%0d]: got %b want 1", i, code_we); else passed++;
      total++; if (code_waddr !== 2'(i)) $display("FAIL load_addr[%0d]: got %0d want %0d", i, code_waddr, i); else passed++;
      total++; if (code_wdata !== d[i]) $display("FAIL load_data[%0d]: got %h want %h", i, code_wdata, d[i]); else passed++;
      @(negedge clk);
      if (i == 0) begin
        total++; if (busy !== 1'b1) $display("FAIL load_busy: got %b want 1", busy); else passed++;
      end
    end
    load_valid = 1'b0; load_last = 1'b0;
    #1;
    total++; if (load_ready !== 1'b0) $display("FAIL ready_load_ready: got %b want 0", load_ready); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL ready_busy: got %b want 0", busy); else passed++;
    total++; if (code_we !== 1'b0) $display("FAIL ready_code_we: got %b want 0", code_we); else passed++;
  endtask

  task automatic test_run_case(input string tag, input bit stuck_i,
                               input int exp_run, input logic [7:0] exp_cyc, input logic [1:0] exp_st);
    int run_cnt = 0;
    int done_cnt = 0;
    stuck = stuck_i;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++; if (core_resetq !== 1'b1) $display("FAIL %s_core_on: got %b want 1", tag, core_resetq); else passed++;
    total++; if (load_ready !== 1'b0) $display("FAIL %s_load_ready: got %b want 0", tag, load_ready); else passed++;
    run_cnt = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (core_resetq) run_cnt++;
      if (done) done_cnt++;
    end
    total++; if (run_cnt !== exp_run) $display("FAIL %s_run_cycles: got %0d want %0d", tag, run_cnt, exp_run); else passed++;
    total++; if (done_cnt !== 1) $display("FAIL %s_done_pulses: got %0d want 1", tag, done_cnt); else passed++;
    total++; if (cycles !== exp_cyc) $display("FAIL %s_cycles: got %0d want %0d", tag, cycles, exp_cyc); else passed++;
    total++; if (status !== exp_st) $display("FAIL %s_status: got %0d want %0d", tag, status, exp_st); else passed++;
    total++; if (core_resetq !== 1'b0) $display("FAIL %s_core_off: got %b want 0", tag, core_resetq); else passed++;
    total++; if (load_ready !== 1'b1) $display("FAIL %s_halt_ready: got %b want 1", tag, load_ready); else passed++;
    stuck = 1'b0;
  endtask

  task automatic test_abort();
    int done_cnt = 0;
    stuck = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    total++; if (core_resetq !== 1'b1) $display("FAIL abort_pre_core: got %b want 1", core_resetq); else passed++;
    @(negedge clk);
    abort = 1'b0;
    total++; if (core_resetq !== 1'b0) $display("FAIL abort_core: got %b want 0", core_resetq); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else passed++;
    total++; if (load_ready !== 1'b1) $display("FAIL abort_load_ready: got %b want 1", load_ready); else passed++;
    for (int i = 0; i < 5; i++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    total++; if (done_cnt !== 0) $display("FAIL abort_done: got %0d want 0", done_cnt); else passed++;
    stuck = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    for (int i = 0; i < 2; i++) begin
      load_valid = 1'b1; load_data = 8'h40 + 8'(i); load_last = 1'b0;
      @(negedge clk);
    end
    load_valid = 1'b0;
    total++; if (busy !== 1'b1) $display("FAIL midload_busy: got %b want 1", busy); else passed++;
    #2 resetq = 1'b0;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
    total++; if (load_ready !== 1'b1) $display("FAIL rst_load_ready: got %b want 1", load_ready); else passed++;
    total++; if (cycles !== 8'd0) $display("FAIL rst_cycles: got %0d want 0", cycles); else passed++;
    total++; if (status !== 2'd0) $display("FAIL rst_status: got %0d want 0", status); else passed++;
    total++; if (core_resetq !== 1'b0) $display("FAIL rst_core: got %b want 0", core_resetq); else passed++;
    @(negedge clk);
    resetq = 1'b1;
    load_valid = 1'b1; load_data = 8'h5A; load_last = 1'b0;
    #1;
    total++; if (code_we !== 1'b1) $display("FAIL rst_reload_we: got %b want 1", code_we); else passed++;
    total++; if (code_waddr !== 2'd0) $display("FAIL rst_reload_addr: got %0d want 0", code_waddr); else passed++;
    @(negedge clk);
    load_valid = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL abort_load_busy: got %b want 0", busy); else passed++;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1; load_data = 8'h10 + 8'(i); load_last = 1'b0;
      #1;
      total++; if (code_waddr !== 2'(i)) $display("FAIL ovf_addr[%0d]: got %0d want %0d", i, code_waddr, i); else passed++;
      total++; if (code_we !== 1'b1) $display("FAIL ovf_we[%0d]: got %b want 1", i, code_we); else passed++;
      @(negedge clk);
    end
    load_valid = 1'b0;
    total++; if (status !== 2'd3) $display("FAIL ovf_status: got %0d want 3", status); else passed++;
    total++; if (done !== 1'b1) $display("FAIL ovf_done: got %b want 1", done); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL ovf_busy: got %b want 0", busy); else passed++;
    @(negedge clk);
    load_valid = 1'b1; load_data = 8'hAA; load_last = 1'b1;
    #1;
    total++; if (code_we !== 1'b1) $display("FAIL halt_load_we: got %b want 1", code_we); else passed++;
    total++; if (code_waddr !== 2'd0) $display("FAIL halt_load_addr: got %0d want 0", code_waddr); else passed++;
    @(negedge clk);
    load_valid = 1'b0; load_last = 1'b0;
    total++; if (load_ready !== 1'b0) $display("FAIL halt_load_ready: got %b want 0", load_ready); else passed++;
    total++; if (done !== 1'b0) $display("FAIL halt_load_done: got %b want 0", done); else passed++;
  endtask

  initial begin
    test_reset();
    test_load();
    test_run_case("run", 1'b0, 3, 8'd3, 2'd1);
    test_run_case("rerun", 1'b0, 3, 8'd3, 2'd1);
    test_run_case("timeout", 1'b1, 8, 8'd8, 2'd2);
    test_abort();
    test_reset_mid_load();
    test_overflow();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
